// File: rtl/instr_decode_stage.sv
// Registered decode stage: splits the instruction word, registers the control
// bundle, spaces memory ops with bubble cycles and counts illegal opcodes.
module instr_decode_stage #(
    parameter int IW      = 9,
    parameter int OPW     = 4,
    parameter int MEM_LAT = 1,
    parameter int CNTW    = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Flush,
    input  logic            InstrValid,
    output logic            InstrReady,
    input  logic [IW-1:0]   Instr,
    output logic            DecValid,
    input  logic            DecReady,
    output logic [OPW-1:0]  DecOp,
    output logic [IW-OPW-1:0] DecImm,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Branch,
    output logic            BranchLink,
    output logic            AluSrcImm,
    output logic            Illegal,
    output logic [CNTW-1:0] IllegalCount
);

    localparam int IMW = IW - OPW;
    localparam int BW  = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    localparam logic [OPW-1:0] LSH  = OPW'(0);
    localparam logic [OPW-1:0] RSH  = OPW'(1);
    localparam logic [OPW-1:0] AND  = OPW'(2);
    localparam logic [OPW-1:0] OR   = OPW'(3);
    localparam logic [OPW-1:0] LDI  = OPW'(4);
    localparam logic [OPW-1:0] LDR  = OPW'(5);
    localparam logic [OPW-1:0] STR  = OPW'(6);
    localparam logic [OPW-1:0] BNZR = OPW'(7);
    localparam logic [OPW-1:0] GEQ  = OPW'(8);
    localparam logic [OPW-1:0] EQ   = OPW'(9);
    localparam logic [OPW-1:0] NEG  = OPW'(10);
    localparam logic [OPW-1:0] ADD  = OPW'(11);
    localparam logic [OPW-1:0] ADDI = OPW'(12);
    localparam logic [OPW-1:0] NEQ  = OPW'(13);
    localparam logic [OPW-1:0] BNZL = OPW'(14);

    typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

    state_t state, state_n;
    logic [BW-1:0] bub_cnt, bub_cnt_n;
    logic [OPW-1:0] op;
    logic accept, mem_gap;
    logic d_rw, d_mr, d_mw, d_br, d_bl, d_ai, d_il;

    assign op       = Instr[IW-1 -: OPW];
    assign DecValid = (state == FULL);
    // A held memory op must leave before anything else may enter.
    assign mem_gap  = (MEM_LAT > 0) && (MemRead || MemWrite);

    always_comb begin
        d_rw = 1'b0;
        d_mr = 1'b0;
        d_mw = 1'b0;
        d_br = 1'b0;
        d_bl = 1'b0;
        d_ai = 1'b0;
        d_il = 1'b0;
        case (op)
            LSH, RSH, LDI, ADDI: begin
                d_rw = 1'b1;
                d_ai = 1'b1;
            end
            AND, OR, GEQ, EQ, NEG, ADD, NEQ: d_rw = 1'b1;
            LDR: begin
                d_rw = 1'b1;
                d_mr = 1'b1;
            end
            STR:  d_mw = 1'b1;
            BNZR: d_br = 1'b1;
            BNZL: begin
                d_rw = 1'b1;
                d_br = 1'b1;
                d_bl = 1'b1;
            end
            default: d_il = 1'b1;
        endcase
    end

    always_comb begin
        InstrReady = 1'b0;
        state_n    = state;
        bub_cnt_n  = bub_cnt;
        if (Reset && !Flush) begin
            InstrReady = (state == EMPTY) ||
                         (state == FULL && DecReady && !mem_gap);
        end
        accept = InstrValid && InstrReady;
        if (Flush) begin
            state_n   = EMPTY;
            bub_cnt_n = '0;
        end else begin
            unique case (state)
                EMPTY: if (accept) state_n = FULL;
                FULL: begin
                    if (DecReady) begin
                        if (mem_gap) begin
                            state_n   = BUBBLE;
                            bub_cnt_n = BW'(MEM_LAT);
                        end else if (!accept) begin
                            state_n = EMPTY;
                        end
                    end
                end
                BUBBLE: begin
                    if (bub_cnt <= BW'(1)) begin
                        state_n   = EMPTY;
                        bub_cnt_n = '0;
                    end else begin
                        bub_cnt_n = bub_cnt - BW'(1);
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= EMPTY;
            bub_cnt <= '0;
        end else begin
            state   <= state_n;
            bub_cnt <= bub_cnt_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            DecOp        <= '0;
            DecImm       <= '0;
            RegWrite     <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            Branch       <= 1'b0;
            BranchLink   <= 1'b0;
            AluSrcImm    <= 1'b0;
            Illegal      <= 1'b0;
            IllegalCount <= '0;
        end else begin
            if (Flush) begin
                DecOp      <= '0;
                DecImm     <= '0;
                RegWrite   <= 1'b0;
                MemRead    <= 1'b0;
                MemWrite   <= 1'b0;
                Branch     <= 1'b0;
                BranchLink <= 1'b0;
                AluSrcImm  <= 1'b0;
                Illegal    <= 1'b0;
            end else if (accept) begin
                DecOp      <= op;
                DecImm     <= Instr[IMW-1:0];
                RegWrite   <= d_rw;
                MemRead    <= d_mr;
                MemWrite   <= d_mw;
                Branch     <= d_br;
                BranchLink <= d_bl;
                AluSrcImm  <= d_ai;
                Illegal    <= d_il;
            end
            if (accept && d_il && IllegalCount != '1) begin
                IllegalCount <= IllegalCount + CNTW'(1);
            end
        end
    end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, parametrised instruction-decode stage for the 3BC processor, placed between instruction fetch and the register file/ALU. It accepts one instruction word per cycle over a valid/ready handshake and splits it into opcode and operand fields. It registers a full control-signal bundle for that opcode, inserts mandatory bubble cycles after memory operations, and flags and counts illegal opcodes. It generalises the fixed 4-bit opcode map to parametrised instruction and opcode widths and adds the flow control, hazard spacing and error tracking the map alone does not provide.

## Interface
- IW, 9: instruction word width.
- OPW, 4: opcode width; opcode = Instr[IW-1 -: OPW]; must satisfy 4 <= OPW < IW.
- MEM_LAT, 1: bubble cycles enforced after an LDR/STR leaves the stage; 0 disables bubbles.
- CNTW, 8: IllegalCount width.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Flush  in  1  discard the held instruction and any pending bubbles.
- InstrValid  in  1  upstream instruction valid.
- InstrReady  out  1  stage can accept this cycle.
- Instr  in  IW  instruction word.
- DecValid  out  1  decoded bundle valid.
- DecReady  in  1  downstream accepts the bundle.
- DecOp  out  OPW  registered opcode.
- DecImm  out  IW-OPW  registered operand field, Instr[IW-OPW-1:0].
- RegWrite, MemRead, MemWrite, Branch, BranchLink, AluSrcImm  out  1 each  control bundle.
- Illegal  out  1  held opcode is unmapped.
- IllegalCount  out  CNTW  saturating count of accepted illegal instructions.

## Operation
- Opcode map, zero-extended to OPW: LSH 0, RSH 1, AND 2, OR 3, LDI 4, LDR 5, STR 6, BNZR 7, GEQ 8, EQ 9, NEG 10, ADD 11, ADDI 12, NEQ 13, BNZL 14. Every opcode >= 15 is illegal.
- Control bundle:
  - RegWrite = all opcodes except STR and BNZR.
  - MemRead = LDR.
  - MemWrite = STR.
  - Branch = BNZR or BNZL.
  - BranchLink = BNZL.
  - AluSrcImm = LSH, RSH, LDI or ADDI.
- Illegal opcode: all six control outputs 0 and Illegal = 1. DecOp and DecImm still carry the raw fields.
- FSM states:
  - EMPTY: no bundle held.
  - FULL: bundle held, DecValid = 1.
  - BUBBLE: post-memory spacing, DecValid = 0, InstrReady = 0.
- InstrReady = Reset & (state==EMPTY | (state==FULL & DecReady & !held-op-is-memory)).
- Accept = InstrValid & InstrReady. Accept loads all output registers.
- Transitions (Flush = 0):
  - EMPTY: accept -> FULL.
  - FULL, DecReady & held LDR/STR & MEM_LAT>0 -> BUBBLE with bubble counter = MEM_LAT. A held LDR/STR with MEM_LAT=0 behaves like any other op.
  - FULL, DecReady & other op: accept -> FULL (back-to-back); no accept -> EMPTY.
  - FULL, !DecReady -> FULL. Outputs hold stable.
  - BUBBLE: counter decrements each cycle; counter reaching 1 -> EMPTY on that edge.
- Flush = 1 (any state) -> EMPTY next cycle. DecValid drops, bubble counter is cleared, and an instruction offered the same cycle is not accepted (InstrReady forced 0). Flush has priority over all transitions.
- IllegalCount increments by 1 on accept of an illegal opcode and saturates at 2^CNTW-1. Flush does not clear it; only Reset does.
- Reset (Reset = 0 at an edge, any state, mid-bubble included):
  - state EMPTY.
  - DecValid, DecOp, DecImm, all control outputs, Illegal and IllegalCount become 0.
  - InstrReady is 0 while Reset is low.

## Timing
- Decode latency 1 cycle: an instruction accepted at edge N has DecValid = 1 after edge N.
- Throughput 1 instruction/cycle for non-memory ops with DecReady held high.
- LDR/STR: the next instruction is accepted no earlier than MEM_LAT+1 cycles after the memory op's handshake edge.
- Control outputs, DecOp, DecImm and Illegal change only on accept, reset, or flush-to-zero. They are constant while DecValid & !DecReady.
- DecValid never depends combinationally on InstrValid.

## Test plan
- Reset, then stream opcodes 0..14 back-to-back with DecReady = 1 -> DecValid high 15 consecutive cycles starting 1 cycle after the first accept; each bundle matches the control table; Illegal stays 0.
- Instr = 9'b1111_00101 -> DecOp = 15, DecImm = 5, all controls 0, Illegal = 1, IllegalCount = 1. Force IllegalCount to 255 with CNTW = 8 and send one more illegal -> count stays 255.
- LDR then ADD offered continuously, MEM_LAT = 2 -> LDR handshake at edge N, two cycles of DecValid = 0/InstrReady = 0, ADD accepted at edge N+3.
- Hold DecReady = 0 for 4 cycles with a valid ADDI held -> outputs stable, InstrReady = 0; DecReady = 1 -> handshake and new accept in the same cycle.
- Flush during BUBBLE with InstrValid = 1 -> no accept that cycle, EMPTY next cycle, InstrReady = 1 after. Flush while FULL -> DecValid = 0 next cycle, IllegalCount unchanged.
- Assert Reset low for 1 cycle mid-bubble -> all outputs 0 next cycle; InstrReady = 0 during reset and 1 after release.
